// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
// Sums fixed-size groups of signed Booth products into a saturating
// accumulator. Each completed group sum is presented on a valid/ready
// result port, which turns the combinational multiplier into a small
// MAC / dot-product datapath.
module booth_product_accumulator #(
  parameter int unsigned PW = 8,
  parameter int unsigned AW = 16,
  parameter int unsigned N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_product,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_sat
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic [AW-1:0] res_q, res_d;
  logic          rsat_q, rsat_d;

  logic [AW:0]   sum_wide;
  logic          ovf;
  logic [AW-1:0] sum_sat;
  logic          accept;
  logic          last;

  // Saturating add of the sign-extended product onto the accumulator.
  // One extra bit of headroom exposes signed overflow in the top two bits.
  always_comb begin
    sum_wide = {acc_q[AW-1], acc_q} + (AW+1)'($signed(in_product));
    ovf      = sum_wide[AW] ^ sum_wide[AW-1];
    sum_sat  = sum_wide[AW-1:0];
    if (ovf) begin
      sum_sat = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
  end

  // Handshake decode; clear and reset both block acceptance.
  always_comb begin
    in_ready  = (state_q == ACCUM) && !clear && !rst;
    out_valid = (state_q == HOLD);
    accept    = in_valid && in_ready;
    last      = (cnt_q == CW'(N - 1));
    out_sum   = res_q;
    out_sat   = rsat_q;
  end

  // Next-state and datapath update for the ACCUM/HOLD controller.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    res_d   = res_q;
    rsat_d  = rsat_q;
    unique case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (accept) begin
          acc_d = sum_sat;
          sat_d = sat_q | ovf;
          if (last) begin
            cnt_d   = '0;
            res_d   = sum_sat;
            rsat_d  = sat_q | ovf;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        // Completed result is held until taken; clear is ignored here.
        if (out_ready) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      res_q   <= '0;
      rsat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      res_q   <= res_d;
      rsat_q  <= rsat_d;
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: two instances (AW=16 and AW=8, N=4)
// share one stimulus stream and are compared against an integer group-sum model.
module tb_booth_product_accumulator;

  localparam int unsigned PW = 8;
  localparam int unsigned N  = 4;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic [PW-1:0] in_product;
  logic          out_ready;
  logic          in_ready_w, in_ready_n;
  logic          out_valid_w, out_valid_n;
  logic [15:0]   out_sum_w;
  logic [7:0]    out_sum_n;
  logic          out_sat_w, out_sat_n;

  booth_product_accumulator #(.PW(PW), .AW(16), .N(N)) u_wide (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_product(in_product),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_sum(out_sum_w), .out_sat(out_sat_w)
  );

  booth_product_accumulator #(.PW(PW), .AW(8), .N(N)) u_narrow (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_product(in_product),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_sum(out_sum_n), .out_sat(out_sat_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: group contents as plain integers.
  bit m_hold;
  int m_cnt;
  int m_acc16, m_acc8;
  bit m_sat16, m_sat8;
  int m_res16, m_res8;
  bit m_rsat16, m_rsat8;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int clamp(input int s, input int aw);
    int hi, lo;
    hi = (1 << (aw - 1)) - 1;
    lo = -(1 << (aw - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_cnt = 0;
    m_acc16 = 0; m_acc8 = 0; m_sat16 = 0; m_sat8 = 0;
    m_res16 = 0; m_res8 = 0; m_rsat16 = 0; m_rsat8 = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".vld16"}, int'(out_valid_w), int'(m_hold));
    chk({tag, ".vld8"},  int'(out_valid_n), int'(m_hold));
    chk({tag, ".sum16"}, int'($signed(out_sum_w)), m_res16);
    chk({tag, ".sum8"},  int'($signed(out_sum_n)), m_res8);
    chk({tag, ".sat16"}, int'(out_sat_w), int'(m_rsat16));
    chk({tag, ".sat8"},  int'(out_sat_n), int'(m_rsat8));
  endtask

  // One clock cycle: drive, check ready before the edge, advance model, check after.
  task automatic cyc(input bit v, input int p, input bit clr, input bit ordy);
    int s;
    in_valid   = v;
    in_product = PW'(p);
    clear      = clr;
    out_ready  = ordy;
    #1;
    chk("rdy16", int'(in_ready_w), int'(!m_hold && !clr));
    chk("rdy8",  int'(in_ready_n), int'(!m_hold && !clr));
    if (!m_hold) begin
      if (clr) begin
        m_acc16 = 0; m_acc8 = 0; m_sat16 = 0; m_sat8 = 0; m_cnt = 0;
      end else if (v) begin
        s = m_acc16 + p; m_acc16 = clamp(s, 16); if (s != m_acc16) m_sat16 = 1;
        s = m_acc8 + p;  m_acc8  = clamp(s, 8);  if (s != m_acc8)  m_sat8  = 1;
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0; m_hold = 1;
          m_res16 = m_acc16; m_rsat16 = m_sat16;
          m_res8  = m_acc8;  m_rsat8  = m_sat8;
        end
      end
    end else if (ordy) begin
      m_hold = 0; m_acc16 = 0; m_acc8 = 0; m_sat16 = 0; m_sat8 = 0;
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic group4(input int a, input int b, input int c, input int d);
    cyc(1, a, 0, 1);
    cyc(1, b, 0, 1);
    cyc(1, c, 0, 1);
    cyc(1, d, 0, 1);
  endtask

  // Asynchronous reset between edges; state must vanish immediately.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.rdy16", int'(in_ready_w), 0);
    chk("rst.rdy8",  int'(in_ready_n), 0);
    check_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    chk("rst.hold.rdy", int'(in_ready_w), 0);
    rst = 1'b0;
    #1;
    chk("rst.rel.rdy16", int'(in_ready_w), 1);
    chk("rst.rel.rdy8",  int'(in_ready_n), 1);
  endtask

  initial begin
    rst = 1'b1; clear = 0; in_valid = 0; in_product = '0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por.rdy", int'(in_ready_w), 0);
    check_outputs("por");
    rst = 1'b0;

    // Basic group with the wide result -38.
    group4(15, -56, 4, -1);
    chk("basic.sum", int'($signed(out_sum_w)), -38);
    cyc(0, 0, 0, 1);

    // Backpressure: HOLD for 5 cycles with input offered.
    group4(15, -56, 4, -1);
    for (int i = 0; i < 5; i++) cyc(1, 7, 0, 0);
    chk("bp.sum", int'($signed(out_sum_w)), -38);
    cyc(1, 7, 0, 1);
    group4(1, 2, 3, 4);
    chk("bp.next", int'($signed(out_sum_w)), 10);
    cyc(0, 0, 0, 1);

    // Positive saturation (narrow instance clamps to 127, ends at 71).
    group4(64, 64, 64, -56);
    chk("psat.sum8", int'($signed(out_sum_n)), 71);
    chk("psat.sat8", int'(out_sat_n), 1);
    cyc(0, 0, 0, 1);
    group4(1, 1, 1, 1);
    chk("psat.next", int'(out_sat_n), 0);
    cyc(0, 0, 0, 1);

    // Negative saturation.
    group4(-56, -56, -56, -56);
    chk("nsat.sum8", int'($signed(out_sum_n)), -128);
    cyc(0, 0, 0, 1);

    // Clear drops partial group and blocks the simultaneous product.
    cyc(1, 10, 0, 1);
    cyc(1, 20, 0, 1);
    cyc(1, 99, 1, 1);
    group4(1, 2, 3, 4);
    chk("clr.sum", int'($signed(out_sum_w)), 10);
    cyc(1, 5, 1, 0);
    cyc(0, 0, 1, 0);
    chk("clr.hold", int'($signed(out_sum_w)), 10);
    cyc(0, 0, 0, 1);

    // Reset mid-group, then a clean group.
    cyc(1, 9, 0, 1);
    cyc(1, 9, 0, 1);
    async_reset();
    group4(1, 1, 1, 1);
    chk("rst.next", int'($signed(out_sum_w)), 4);
    cyc(0, 0, 0, 1);

    // Reset while holding a result.
    group4(3, 3, 3, 3);
    async_reset();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 120)) - 56,
          bit'($urandom_range(0, 15) == 0),
          bit'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
